// File: rtl/ws_systolic_engine.sv
// Weight-stationary systolic MAC array with input/psum skew, output deskew,
// double-buffered weights and a whole-pipeline valid/ready stall.

module ws_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] line_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) line_reg[i] <= '0;
    end else if (en) begin
      line_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) line_reg[i] <= line_reg[i-1];
    end
  end

  assign q = line_reg[DEPTH-1];
endmodule

module ws_systolic_engine #(
  parameter int IFMAP_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int OFMAP_WIDTH  = 32,
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  localparam int ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      ifmap_valid,
  output logic                                      ifmap_ready,
  input  logic [ARRAY_HEIGHT-1:0][IFMAP_WIDTH-1:0]  ifmap_in,
  input  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]   ofmap_in,
  input  logic                                      weight_valid,
  output logic                                      weight_ready,
  input  logic [ROW_W-1:0]                          weight_row,
  input  logic [ARRAY_WIDTH-1:0][WEIGHT_WIDTH-1:0]  weight_in,
  input  logic                                      weight_commit,
  output logic                                      ofmap_valid,
  input  logic                                      ofmap_ready,
  output logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]   ofmap_out
);
  localparam int DEPTH   = ARRAY_HEIGHT + ARRAY_WIDTH;
  localparam int DRAIN_W = $clog2(DEPTH + 1);
  localparam int PROD_W  = IFMAP_WIDTH + WEIGHT_WIDTH;

  logic adv;
  assign adv         = ofmap_ready | ~ofmap_valid;
  assign ifmap_ready = adv;

  logic [WEIGHT_WIDTH-1:0] weight_bank_reg [2][ARRAY_HEIGHT][ARRAY_WIDTH];
  logic                    active_bank_reg;
  logic [DRAIN_W-1:0]      drain_reg;
  logic                    write_en;
  logic                    commit_en;

  assign weight_ready = (drain_reg == '0);
  assign write_en     = weight_valid & weight_ready & (32'(weight_row) < ARRAY_HEIGHT);
  assign commit_en    = weight_commit & weight_ready;

  // Writes target the inactive bank as sampled this cycle, so a same-cycle
  // commit makes the freshly written row part of the new active bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int y = 0; y < ARRAY_HEIGHT; y++)
          for (int x = 0; x < ARRAY_WIDTH; x++)
            weight_bank_reg[b][y][x] <= '0;
    end else if (write_en) begin
      for (int x = 0; x < ARRAY_WIDTH; x++)
        weight_bank_reg[~active_bank_reg][weight_row][x] <= weight_in[x];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank_reg <= 1'b0;
      drain_reg       <= '0;
    end else if (commit_en) begin
      active_bank_reg <= ~active_bank_reg;
      drain_reg       <= DRAIN_W'(DEPTH);
    end else if (adv && drain_reg != '0) begin
      drain_reg <= drain_reg - DRAIN_W'(1);
    end
  end

  // Stage d of these lines holds the beat whose data sits at PEs with x+y == d.
  logic [DEPTH-1:0] valid_line_reg;
  logic [DEPTH-2:0] tag_line_reg;
  logic             ofmap_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_line_reg  <= '0;
      tag_line_reg    <= '0;
      ofmap_valid_reg <= 1'b0;
    end else if (adv) begin
      valid_line_reg[0] <= ifmap_valid;
      for (int i = 1; i < DEPTH; i++) valid_line_reg[i] <= valid_line_reg[i-1];
      tag_line_reg[0] <= active_bank_reg;
      for (int i = 1; i < DEPTH - 1; i++) tag_line_reg[i] <= tag_line_reg[i-1];
      ofmap_valid_reg <= valid_line_reg[DEPTH-1];
    end
  end

  assign ofmap_valid = ofmap_valid_reg;

  logic [ARRAY_HEIGHT-1:0][IFMAP_WIDTH-1:0] in_ifmap_reg;
  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0]  in_psum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ifmap_reg <= '0;
      in_psum_reg  <= '0;
    end else if (adv) begin
      in_ifmap_reg <= ifmap_in;
      in_psum_reg  <= ofmap_in;
    end
  end

  logic [IFMAP_WIDTH-1:0] row_in [ARRAY_HEIGHT];
  logic [OFMAP_WIDTH-1:0] col_in [ARRAY_WIDTH];
  logic [IFMAP_WIDTH-1:0] act_reg  [ARRAY_WIDTH][ARRAY_HEIGHT];
  logic [OFMAP_WIDTH-1:0] psum_reg [ARRAY_WIDTH][ARRAY_HEIGHT];

  genvar gi, gj;

  for (gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_row_skew
    if (gi == 0) begin : g_direct
      assign row_in[gi] = in_ifmap_reg[gi];
    end else begin : g_delay
      ws_delay_line #(.WIDTH(IFMAP_WIDTH), .DEPTH(gi)) u_skew (
        .clk(clk), .rst_n(rst_n), .en(adv), .d(in_ifmap_reg[gi]), .q(row_in[gi])
      );
    end
  end

  for (gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_col_skew
    if (gi == 0) begin : g_direct
      assign col_in[gi] = in_psum_reg[gi];
    end else begin : g_delay
      ws_delay_line #(.WIDTH(OFMAP_WIDTH), .DEPTH(gi)) u_skew (
        .clk(clk), .rst_n(rst_n), .en(adv), .d(in_psum_reg[gi]), .q(col_in[gi])
      );
    end
  end

  for (gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_pe_col
    for (gj = 0; gj < ARRAY_HEIGHT; gj++) begin : g_pe_row
      logic [IFMAP_WIDTH-1:0]   act_in;
      logic [OFMAP_WIDTH-1:0]   psum_in;
      logic [WEIGHT_WIDTH-1:0]  weight_sel;
      logic signed [PROD_W-1:0] prod;

      if (gi == 0) begin : g_act_edge
        assign act_in = row_in[gj];
      end else begin : g_act_chain
        assign act_in = act_reg[gi-1][gj];
      end

      if (gj == 0) begin : g_psum_edge
        assign psum_in = col_in[gi];
      end else begin : g_psum_chain
        assign psum_in = psum_reg[gi][gj-1];
      end

      assign weight_sel = weight_bank_reg[tag_line_reg[gi+gj]][gj][gi];
      assign prod = PROD_W'($signed(act_in)) * PROD_W'($signed(weight_sel));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act_reg[gi][gj]  <= '0;
          psum_reg[gi][gj] <= '0;
        end else if (adv) begin
          act_reg[gi][gj]  <= act_in;
          psum_reg[gi][gj] <= psum_in + OFMAP_WIDTH'(prod);
        end
      end
    end
  end

  // Deskew depth includes the final output register.
  for (gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_deskew
    ws_delay_line #(.WIDTH(OFMAP_WIDTH), .DEPTH(ARRAY_WIDTH - gi)) u_deskew (
      .clk(clk), .rst_n(rst_n), .en(adv), .d(psum_reg[gi][ARRAY_HEIGHT-1]), .q(ofmap_out[gi])
    );
  end
endmodule

// File: tb/tb_ws_systolic_engine.sv
// Randomized bench for ws_systolic_engine: a per-beat arithmetic model with
// latency bookkeeping is checked against the DUT on every cycle.

module tb_ws_systolic_engine;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int IW = 16;
  localparam int WW = 16;
  localparam int OW = 32;
  localparam int RW = 2;
  localparam int VW = W * OW;

  typedef logic [W-1:0][OW-1:0] vec_t;
  typedef struct {
    int   due;
    vec_t data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ifmap_valid = 1'b0;
  logic ifmap_ready;
  logic [H-1:0][IW-1:0] ifmap_in = '0;
  vec_t ofmap_in = '0;
  logic weight_valid = 1'b0;
  logic weight_ready;
  logic [RW-1:0] weight_row = '0;
  logic [W-1:0][WW-1:0] weight_in = '0;
  logic weight_commit = 1'b0;
  logic ofmap_valid;
  logic ofmap_ready = 1'b1;
  vec_t ofmap_out;

  always #5 clk = ~clk;

  ws_systolic_engine dut (
    .clk(clk), .rst_n(rst_n),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_in(ifmap_in),
    .ofmap_in(ofmap_in),
    .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_row(weight_row),
    .weight_in(weight_in), .weight_commit(weight_commit),
    .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready), .ofmap_out(ofmap_out)
  );

  // Reference: each accepted beat's result is computed at acceptance from the
  // bank it was tagged with, and is due once H+W advancing cycles have passed.
  exp_t exp_q[$];
  int   m_w [2][H][W];
  int   m_active;
  int   m_drain;
  int   adv_cnt;
  int   vectors;
  int   miscompares;
  int   out_beats;

  function automatic vec_t golden(input logic [H-1:0][IW-1:0] a, input vec_t p, input int bank);
    vec_t r;
    for (int x = 0; x < W; x++) begin
      int acc;
      acc = int'(p[x]);
      for (int y = 0; y < H; y++) acc += int'($signed(a[y])) * m_w[bank][y][x];
      r[x] = acc;
    end
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) m_w[b][y][x] = 0;
    m_active = 0;
    m_drain  = 0;
  endtask

  task automatic model_edge();
    bit vnow;
    bit adv;
    if (!rst_n) return;
    vnow = (exp_q.size() > 0) && (exp_q[0].due == adv_cnt);
    adv  = ofmap_ready || !vnow;
    if (adv) begin
      if (vnow) void'(exp_q.pop_front());
      adv_cnt++;
      if (ifmap_valid) exp_q.push_back('{due: adv_cnt + H + W, data: golden(ifmap_in, ofmap_in, m_active)});
    end
    if (m_drain == 0) begin
      if (weight_valid && int'(weight_row) < H)
        for (int x = 0; x < W; x++) m_w[1 - m_active][weight_row][x] = int'($signed(weight_in[x]));
      if (weight_commit) begin
        m_active = 1 - m_active;
        m_drain  = H + W;
      end
    end else if (adv) begin
      m_drain--;
    end
  endtask

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_cycle();
    bit vnow;
    if (!rst_n) begin
      chk("rst_ofmap_valid", ofmap_valid, 1'b0);
      chk("rst_ofmap_out", ofmap_out, '0);
      chk("rst_weight_ready", weight_ready, 1'b1);
      chk("rst_ifmap_ready", ifmap_ready, 1'b1);
      return;
    end
    vnow = (exp_q.size() > 0) && (exp_q[0].due == adv_cnt);
    chk("ofmap_valid", ofmap_valid, vnow);
    chk("ifmap_ready", ifmap_ready, ofmap_ready || !vnow);
    chk("weight_ready", weight_ready, m_drain == 0);
    if (vnow) begin
      chk("ofmap_out", ofmap_out, exp_q[0].data);
      if (ofmap_ready) begin
        $display("out beat %0d: %h", out_beats, ofmap_out);
        out_beats++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle();
    ifmap_valid   = 1'b0;
    weight_valid  = 1'b0;
    weight_commit = 1'b0;
  endtask

  task automatic rand_beat();
    ifmap_valid = 1'b1;
    for (int y = 0; y < H; y++) ifmap_in[y] = IW'($urandom);
    for (int x = 0; x < W; x++) ofmap_in[x] = $urandom;
  endtask

  task automatic flush();
    idle();
    ofmap_ready = 1'b1;
    repeat (H + W + 2) tick();
  endtask

  task automatic wait_wready();
    int n = 0;
    while (!weight_ready && n < 64) begin
      tick();
      n++;
    end
    chk("weight_ready_timeout", weight_ready, 1'b1);
  endtask

  task automatic write_row(input int row, input logic [W-1:0][WW-1:0] w);
    weight_valid = 1'b1;
    weight_row   = RW'(row);
    weight_in    = w;
    tick();
    weight_valid = 1'b0;
  endtask

  task automatic commit();
    weight_commit = 1'b1;
    tick();
    weight_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0][WW-1:0] wrow;
    vec_t want;
    int   low_cnt;
    int   s;

    vectors = 0;
    miscompares = 0;
    out_beats = 0;
    adv_cnt = 0;
    model_clear();

    repeat (2) tick();
    rst_n = 1'b1;

    // Identity weights, then one beat with a fixed 8-cycle latency.
    for (int y = 0; y < H; y++) begin
      wrow = '0;
      wrow[y] = WW'(1);
      write_row(y, wrow);
    end
    commit();
    ifmap_valid = 1'b1;
    ifmap_in = {16'd4, 16'd3, 16'd2, 16'd1};
    ofmap_in = '0;
    tick();
    chk("pin_identity_model", exp_q[$].data, {32'd4, 32'd3, 32'd2, 32'd1});
    idle();
    for (int i = 1; i < H + W; i++) begin
      tick();
      chk("latency_early", ofmap_valid, 1'b0);
    end
    tick();
    chk("latency_8", ofmap_valid, 1'b1);
    chk("identity_out", ofmap_out, {32'd4, 32'd3, 32'd2, 32'd1});
    flush();

    // Back-to-back stream with a tile switch after beat 7 and an ignored
    // write+commit while the drain guard is active.
    wait_wready();
    low_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      rand_beat();
      weight_valid  = (i < H);
      weight_row    = RW'(i);
      weight_in     = {W{16'd1}};
      weight_commit = (i == 7);
      if (i == 10) begin
        weight_valid  = 1'b1;
        weight_row    = '0;
        weight_in     = {W{16'd5}};
        weight_commit = 1'b1;
      end
      tick();
      if (i == 7) begin
        for (int x = 0; x < W; x++) want[x] = ofmap_in[x] + OW'(int'($signed(ifmap_in[x])));
        chk("pin_beat7_identity", exp_q[$].data, want);
      end
      if (i == 8) begin
        s = 0;
        for (int y = 0; y < H; y++) s += int'($signed(ifmap_in[y]));
        for (int x = 0; x < W; x++) want[x] = ofmap_in[x] + OW'(s);
        chk("pin_beat8_ones", exp_q[$].data, want);
      end
      if (i >= 7 && !weight_ready) low_cnt++;
    end
    idle();
    chk("weight_ready_low_cycles", low_cnt, 8);
    flush();

    // Backpressure window, then random valid/ready traffic.
    for (int i = 0; i < 20; i++) begin
      rand_beat();
      ofmap_ready = !(i >= 8 && i < 13);
      tick();
      if (i == 10) chk("bp_ifmap_ready_low", ifmap_ready, 1'b0);
    end
    for (int i = 0; i < 80; i++) begin
      rand_beat();
      ifmap_valid = ($urandom_range(0, 3) != 0);
      ofmap_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    flush();

    // Two's-complement wrap with maximal operands.
    wait_wready();
    for (int y = 0; y < H; y++) write_row(y, {W{16'h7FFF}});
    commit();
    ifmap_valid = 1'b1;
    ifmap_in = {H{16'h7FFF}};
    ofmap_in = {W{32'h7FFFFFFF}};
    tick();
    chk("pin_wrap_model", exp_q[$].data, {W{32'h7FFC0003}});
    flush();

    // Reset with beats in flight and one result on the output.
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    idle();
    repeat (H + W - 3 + 1) tick();
    chk("pre_reset_valid", ofmap_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("reset_mid_valid", ofmap_valid, 1'b0);
    chk("reset_mid_wready", weight_ready, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;
    rand_beat();
    tick();
    chk("pin_post_reset_zero_banks", exp_q[$].data, ofmap_in);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
